// File: rtl/alu_req_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM
// state encoding and the arbitration decision.
package alu_req_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Returns the index of the requester that wins this cycle. With both
  // requesting, round-robin hands the slot to whoever did not win last;
  // fixed priority always favours requester 0.
  function automatic logic rr_pick(input logic v0, input logic v1,
                                   input logic last_grant, input logic rr_en);
    logic g;
    if (v0 && v1) begin
      g = rr_en ? ~last_grant : 1'b0;
    end else if (v0) begin
      g = 1'b0;
    end else begin
      g = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Handshake bundle between the two requesters, the result consumer and
// the arbiter. The arbiter uses the slave view; the requester/consumer
// side uses the master view.
interface alu_req_arbiter_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic             req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res_valid;
  logic             res_ready;
  logic             res_id;
  logic [WIDTH-1:0] res_data;
  logic             res_carry;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_id, res_data, res_carry, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_id, res_data, res_carry, busy
  );

endinterface

// File: rtl/alu_req_arbiter_alu_core.sv
// Combinational ALU: ADD with carry-out, bitwise AND/OR/XOR with carry 0.
module alu_core
  import alu_req_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             carry
);

  logic [WIDTH:0] sum;

  // Evaluate the selected operation; the sum is one bit wider so the
  // carry falls out of the top bit.
  always_comb begin
    sum   = {1'b0, a} + {1'b0, b};
    y     = '0;
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum[WIDTH-1:0];
        carry = sum[WIDTH];
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Two requesters share one registered ALU. One operation in flight:
// IDLE accepts a request, EXEC computes, RESP holds the result until the
// consumer takes it.
module alu_req_arbiter
  import alu_req_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter bit RR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  alu_req_arbiter_if.slave  bus
);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             id_q, id_d;
  logic             res_valid_q, res_valid_d;
  logic             res_id_q, res_id_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_carry_q, res_carry_d;
  logic             busy_q, busy_d;

  logic             grant;
  logic             rdy0;
  logic             rdy1;
  logic [WIDTH-1:0] alu_y;
  logic             alu_carry;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .y     (alu_y),
    .carry (alu_carry)
  );

  // Arbitration is purely combinational and only matters in IDLE.
  always_comb begin
    grant = rr_pick(bus.req0_valid, bus.req1_valid, last_grant_q, RR_EN);
  end

  assign rdy0 = (state_q == IDLE) && bus.req0_valid && (grant == 1'b0);
  assign rdy1 = (state_q == IDLE) && bus.req1_valid && (grant == 1'b1);

  assign bus.req0_ready = rdy0;
  assign bus.req1_ready = rdy1;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_carry  = res_carry_q;
  assign bus.busy       = busy_q;

  // Next-state and datapath update for the IDLE -> EXEC -> RESP cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    id_d         = id_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_data_d   = res_data_q;
    res_carry_d  = res_carry_q;
    case (state_q)
      IDLE: begin
        if (rdy0 || rdy1) begin
          op_d         = grant ? bus.req1_op : bus.req0_op;
          a_d          = grant ? bus.req1_a  : bus.req0_a;
          b_d          = grant ? bus.req1_b  : bus.req0_b;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        res_data_d  = alu_y;
        res_carry_d = alu_carry;
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // Result fields stay untouched here so the consumer sees them stable.
        if (res_valid_q && bus.res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        res_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Register all state; reset discards any in-flight op and makes req0
  // the winner of the next contention.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= 2'b00;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_data_q   <= '0;
      res_carry_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      id_q         <= id_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_data_q   <= res_data_d;
      res_carry_q  <= res_carry_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a round-robin instance driven by directed and
// random transactions against a transaction-level reference, plus a
// fixed-priority instance.
module tb_alu_req_arbiter;
  import alu_req_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_req_arbiter_if #(.WIDTH(8)) ifc ();
  alu_req_arbiter_if #(.WIDTH(8)) ifp ();

  alu_req_arbiter #(.WIDTH(8), .RR_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  alu_req_arbiter #(.WIDTH(8), .RR_EN(1'b0)) dut_fp (
    .clk   (clk),
    .reset (reset),
    .bus   (ifp)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: who won last, and each requester's pending request.
  bit         last_g;
  bit         p0, p1;
  logic [1:0] po0, po1;
  logic [7:0] pa0, pb0, pa1, pb1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Result of an operation from its arithmetic definition: {carry, data}.
  function automatic logic [8:0] ref_alu(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    logic [8:0] r;
    case (op)
      2'd0: begin
        s = int'(a) + int'(b);
        r = s[8:0];
      end
      2'd1: r = {1'b0, a & b};
      2'd2: r = {1'b0, a | b};
      default: r = {1'b0, a ^ b};
    endcase
    return r;
  endfunction

  task automatic new_req0();
    p0  = 1'b1;
    po0 = 2'($urandom_range(0, 3));
    pa0 = 8'($urandom_range(0, 255));
    pb0 = 8'($urandom_range(0, 255));
  endtask

  task automatic new_req1();
    p1  = 1'b1;
    po1 = 2'($urandom_range(0, 3));
    pa1 = 8'($urandom_range(0, 255));
    pb1 = 8'($urandom_range(0, 255));
  endtask

  task automatic drive_reqs();
    ifc.req0_valid = p0;
    ifc.req0_op    = po0;
    ifc.req0_a     = pa0;
    ifc.req0_b     = pb0;
    ifc.req1_valid = p1;
    ifc.req1_op    = po1;
    ifc.req1_a     = pa1;
    ifc.req1_b     = pb1;
  endtask

  // One complete transaction on the round-robin instance, entered shortly
  // after a falling edge with the arbiter idle. The loser (if any) keeps
  // its request pending when keep_loser is set.
  task automatic run_txn(input int hold, input bit keep_loser);
    bit         g;
    logic [8:0] e;
    drive_reqs();
    ifc.res_ready = 1'b0;
    #1;
    g = (p0 && p1) ? !last_g : !p0;
    chk("grant_rdy0", 32'(ifc.req0_ready), 32'(g == 1'b0));
    chk("grant_rdy1", 32'(ifc.req1_ready), 32'(g));
    e = g ? ref_alu(po1, pa1, pb1) : ref_alu(po0, pa0, pb0);
    @(negedge clk);
    last_g = g;
    if (g) p1 = 1'b0; else p0 = 1'b0;
    if (!keep_loser) begin
      p0 = 1'b0;
      p1 = 1'b0;
    end
    drive_reqs();
    #1;
    chk("exec_busy", 32'(ifc.busy), 32'd1);
    chk("exec_rdy", 32'({ifc.req0_ready, ifc.req1_ready}), 32'd0);
    chk("exec_res_valid", 32'(ifc.res_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("resp_valid", 32'(ifc.res_valid), 32'd1);
    chk("resp_id", 32'(ifc.res_id), 32'(g));
    chk("resp_data", 32'(ifc.res_data), 32'(e[7:0]));
    chk("resp_carry", 32'(ifc.res_carry), 32'(e[8]));
    chk("resp_busy", 32'(ifc.busy), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      #1;
      chk("hold_valid", 32'(ifc.res_valid), 32'd1);
      chk("hold_data", 32'({ifc.res_carry, ifc.res_data}), 32'(e));
      chk("hold_id", 32'(ifc.res_id), 32'(g));
      chk("hold_rdy", 32'({ifc.req0_ready, ifc.req1_ready}), 32'd0);
      chk("hold_busy", 32'(ifc.busy), 32'd1);
    end
    ifc.res_ready = 1'b1;
    @(negedge clk);
    ifc.res_ready = 1'b0;
    #1;
    chk("done_valid", 32'(ifc.res_valid), 32'd0);
    chk("done_busy", 32'(ifc.busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [8:0] fe;

    // Reset with random payloads, valids low.
    reset = 1'b1;
    p0 = 1'b0; p1 = 1'b0;
    po0 = 2'($urandom_range(0, 3)); pa0 = 8'($urandom); pb0 = 8'($urandom);
    po1 = 2'($urandom_range(0, 3)); pa1 = 8'($urandom); pb1 = 8'($urandom);
    drive_reqs();
    ifc.res_ready  = 1'($urandom_range(0, 1));
    ifp.req0_valid = 1'b0; ifp.req0_op = 2'd0; ifp.req0_a = 8'($urandom); ifp.req0_b = 8'd0;
    ifp.req1_valid = 1'b0; ifp.req1_op = 2'd0; ifp.req1_a = 8'd0; ifp.req1_b = 8'($urandom);
    ifp.res_ready  = 1'($urandom_range(0, 1));
    last_g = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("rst_res_id", 32'(ifc.res_id), 32'd0);
    chk("rst_res_data", 32'(ifc.res_data), 32'd0);
    chk("rst_res_carry", 32'(ifc.res_carry), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_rdy", 32'({ifc.req0_ready, ifc.req1_ready}), 32'd0);
    chk("rst_fp_out", 32'({ifp.res_valid, ifp.busy, ifp.res_data}), 32'd0);
    reset = 1'b0;
    ifc.res_ready = 1'b0;
    @(negedge clk);
    #1;

    // req0 ADD 0x12 + 0x34.
    p0 = 1'b1; po0 = OP_ADD; pa0 = 8'h12; pb0 = 8'h34;
    run_txn(0, 1'b0);
    // req1 ADD 0xFF + 0x01 wraps with carry, then XOR.
    p1 = 1'b1; po1 = OP_ADD; pa1 = 8'hFF; pb1 = 8'h01;
    run_txn(0, 1'b0);
    p1 = 1'b1; po1 = OP_XOR; pa1 = 8'hAA; pb1 = 8'hFF;
    run_txn(0, 1'b0);

    // Both requesting continuously: slot alternates.
    p0 = 1'b1; po0 = OP_OR;  pa0 = 8'h0F; pb0 = 8'hF0;
    p1 = 1'b1; po1 = OP_AND; pa1 = 8'hF0; pb1 = 8'h3C;
    for (int k = 0; k < 4; k++) begin
      if (!p0) begin p0 = 1'b1; po0 = OP_OR; pa0 = 8'h0F; pb0 = 8'hF0; end
      if (!p1) begin p1 = 1'b1; po1 = OP_AND; pa1 = 8'hF0; pb1 = 8'h3C; end
      run_txn(0, 1'b1);
    end
    // Consumer stalls five cycles in RESP.
    if (!p0 && !p1) new_req0();
    run_txn(5, 1'b0);

    // Random traffic.
    for (int k = 0; k < 30; k++) begin
      if (!p0 && $urandom_range(0, 2) != 0) new_req0();
      if (!p1 && $urandom_range(0, 2) != 0) new_req1();
      if (!p0 && !p1) new_req1();
      run_txn(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    while (p0 || p1) run_txn(0, 1'b0);

    // Reset during EXEC.
    new_req1();
    p0 = 1'b0;
    drive_reqs();
    #1;
    chk("rx_rdy1", 32'(ifc.req1_ready), 32'd1);
    @(negedge clk);
    p1 = 1'b0;
    drive_reqs();
    #2 reset = 1'b1;
    #1;
    chk("rx_exec_valid", 32'(ifc.res_valid), 32'd0);
    chk("rx_exec_busy", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_g = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rx_exec_noresult", 32'(ifc.res_valid), 32'd0);
    new_req0(); new_req1();
    run_txn(0, 1'b0);

    // Reset during RESP.
    new_req1();
    drive_reqs();
    @(negedge clk);
    p1 = 1'b0;
    drive_reqs();
    @(negedge clk);
    #1;
    chk("rx_resp_pre", 32'(ifc.res_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("rx_resp_valid", 32'(ifc.res_valid), 32'd0);
    chk("rx_resp_busy", 32'(ifc.busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    last_g = 1'b1;
    @(negedge clk);
    #1;
    chk("rx_resp_noresult", 32'(ifc.res_valid), 32'd0);
    new_req0(); new_req1();
    run_txn(0, 1'b0);

    // Fixed-priority instance: req0 takes every slot.
    for (int k = 0; k < 6; k++) begin
      ifp.req0_valid = 1'b1;
      ifp.req0_op    = 2'($urandom_range(0, 3));
      ifp.req0_a     = 8'($urandom);
      ifp.req0_b     = 8'($urandom);
      ifp.req1_valid = 1'b1;
      ifp.req1_op    = 2'($urandom_range(0, 3));
      ifp.req1_a     = 8'($urandom);
      ifp.req1_b     = 8'($urandom);
      ifp.res_ready  = 1'b1;
      #1;
      chk("fp_rdy0", 32'(ifp.req0_ready), 32'd1);
      chk("fp_rdy1", 32'(ifp.req1_ready), 32'd0);
      fe = ref_alu(ifp.req0_op, ifp.req0_a, ifp.req0_b);
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("fp_id", 32'(ifp.res_id), 32'd0);
      chk("fp_data", 32'({ifp.res_carry, ifp.res_data}), 32'(fe));
      @(negedge clk);
      #1;
    end
    ifp.req0_valid = 1'b0;
    ifp.req1_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
